// File: rtl/shenjing_pkg.sv
// Shared types and default widths for the neuron input/output pipeline.
// The default widths are shared with spike_gen so the partial sum lines up with its threshold test.
package shenjing_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} accum_state_e;

   localparam int NUM_AXON_DEF     = 256;
   localparam int WEIGHT_WIDTH_DEF = 8;
   localparam int ADDER_WIDTH_DEF  = 16;

endpackage

// File: rtl/spike_accum_if.sv
// Handshake and SRAM signals around spike_accum.
// The slave modport is the accumulator; the master modport is its environment (router, weight SRAM, spike_gen).
interface spike_accum_if #(
   parameter int NUM_AXON     = shenjing_pkg::NUM_AXON_DEF,
   parameter int AXON_IDX_W   = $clog2(NUM_AXON),
   parameter int WEIGHT_WIDTH = shenjing_pkg::WEIGHT_WIDTH_DEF,
   parameter int SUM_WIDTH    = shenjing_pkg::ADDER_WIDTH_DEF
);
   logic                    spike_vld;
   logic                    spike_rdy;
   logic [NUM_AXON-1:0]     spike_vec;
   logic                    wt_rd_en;
   logic [AXON_IDX_W-1:0]   wt_addr;
   logic [WEIGHT_WIDTH-1:0] wt_data;
   logic                    sum_vld;
   logic                    sum_rdy;
   logic [SUM_WIDTH-1:0]    input_sum;

   modport slave (
      input  spike_vld, spike_vec, wt_data, sum_rdy,
      output spike_rdy, wt_rd_en, wt_addr, sum_vld, input_sum
   );

   modport master (
      output spike_vld, spike_vec, wt_data, sum_rdy,
      input  spike_rdy, wt_rd_en, wt_addr, sum_vld, input_sum
   );
endinterface

// File: rtl/spike_accum.sv
// Neuron input stage: walks one spike vector an axon per cycle, fetches weights for set bits
// and accumulates them into a wrapping partial sum offered to spike_gen.
module spike_accum
   import shenjing_pkg::*;
#(
   parameter int NUM_AXON     = NUM_AXON_DEF,
   parameter int AXON_IDX_W   = $clog2(NUM_AXON),
   parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter int ADDER_WIDTH  = ADDER_WIDTH_DEF,
   parameter int SUM_WIDTH    = ADDER_WIDTH
) (
   input  logic           clk,
   input  logic           rstb,
   spike_accum_if.slave   bus
);

   accum_state_e          state_q, state_d;
   logic [NUM_AXON-1:0]   vec_q, vec_d;
   logic [AXON_IDX_W-1:0] idx_q, idx_d;
   logic [SUM_WIDTH-1:0]  acc_q, acc_d;
   logic                  rd_pend_q;
   logic                  rd_en;
   logic [SUM_WIDTH-1:0]  wt_ext;

   // Every axon gets a slot, set or not, so the scan length never depends on spike count.
   assign rd_en  = (state_q == SCAN) && vec_q[idx_q];
   assign wt_ext = {{(SUM_WIDTH-WEIGHT_WIDTH){bus.wt_data[WEIGHT_WIDTH-1]}}, bus.wt_data};

   assign bus.spike_rdy = (state_q == IDLE);
   assign bus.wt_rd_en  = rd_en;
   assign bus.wt_addr   = idx_q;
   assign bus.sum_vld   = (state_q == DONE);
   assign bus.input_sum = acc_q;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      idx_d   = idx_q;
      acc_d   = acc_q;

      // Read data lands one cycle after the strobe, so the last weight is added in DRAIN.
      if (rd_pend_q && (state_q == SCAN || state_q == DRAIN)) begin
         acc_d = acc_q + wt_ext;
      end

      case (state_q)
         IDLE: begin
            if (bus.spike_vld) begin
               vec_d   = bus.spike_vec;
               acc_d   = '0;
               idx_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (idx_q == AXON_IDX_W'(NUM_AXON-1)) begin
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + AXON_IDX_W'(1);
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (bus.sum_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         rd_pend_q <= rd_en;
      end
   end

endmodule

// File: tb/tb_spike_accum.sv
// Directed bench for spike_accum: 1-cycle weight SRAM model, latency/sum/read-count checks,
// backpressure, ignored spike_vld outside IDLE, and asynchronous reset mid-scan.
module tb_spike_accum;

   localparam int NA = 256;
   localparam int IW = 8;
   localparam int WW = 8;
   localparam int SW = 16;
   localparam int LAT = NA + 2;

   logic clk  = 1'b0;
   logic rstb = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [WW-1:0] mem [NA];
   int            rd_log [$];

   spike_accum_if #(.NUM_AXON(NA), .AXON_IDX_W(IW), .WEIGHT_WIDTH(WW), .SUM_WIDTH(SW)) bus ();

   spike_accum #(
      .NUM_AXON(NA), .AXON_IDX_W(IW), .WEIGHT_WIDTH(WW), .ADDER_WIDTH(SW), .SUM_WIDTH(SW)
   ) u_dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Weight SRAM: data valid exactly one cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.wt_rd_en) bus.wt_data <= mem[bus.wt_addr];
   end

   always @(negedge clk) begin
      if (rstb && bus.wt_rd_en) rd_log.push_back(int'(bus.wt_addr));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end else begin
         $display("ok   %s: %0d (0x%0h)", tag, obs, obs);
      end
   endtask

   task automatic fill_mem(input logic [WW-1:0] even_w, input logic [WW-1:0] odd_w);
      for (int i = 0; i < NA; i++) mem[i] = (i % 2 == 0) ? even_w : odd_w;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.spike_rdy && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!bus.spike_rdy) chk({tag, "_idle_timeout"}, bus.spike_rdy, 1);
   endtask

   function automatic int log_at(input int pos);
      return (rd_log.size() > pos) ? rd_log[pos] : -1;
   endfunction

   // Sends one vector with sum_rdy held high; checks latency, sum, handback and read count.
   task automatic run_vec(input string tag, input logic [NA-1:0] vec, input logic [SW-1:0] exp_sum,
                          input int exp_reads, output int r0);
      int lat;
      wait_idle(tag);
      r0 = rd_log.size();
      bus.sum_rdy   = 1'b1;
      bus.spike_vec = vec;
      bus.spike_vld = 1'b1;
      @(negedge clk);
      bus.spike_vld = 1'b0;
      lat = 1;
      while (!bus.sum_vld && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_sum"}, bus.input_sum, exp_sum);
      @(negedge clk);
      chk({tag, "_vld_drop"}, bus.sum_vld, 0);
      chk({tag, "_rdy_back"}, bus.spike_rdy, 1);
      chk({tag, "_reads"}, rd_log.size() - r0, exp_reads);
      $display("xfer %s: latency=%0d sum=0x%0h reads=%0d", tag, lat, bus.input_sum, rd_log.size() - r0);
   endtask

   logic [NA-1:0] sparse_vec;

   initial begin
      int r0, n, good;

      bus.spike_vld = 1'b0;
      bus.spike_vec = '0;
      bus.sum_rdy   = 1'b0;
      sparse_vec    = '0;
      sparse_vec[0]   = 1'b1;
      sparse_vec[5]   = 1'b1;
      sparse_vec[255] = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_spike_rdy", bus.spike_rdy, 1);
      chk("reset_sum_vld", bus.sum_vld, 0);
      chk("reset_wt_rd_en", bus.wt_rd_en, 0);
      chk("reset_wt_addr", bus.wt_addr, 0);
      chk("reset_input_sum", bus.input_sum, 0);
      rstb = 1'b1;

      // Sparse vector: unused axons carry 50 so any stray read corrupts the sum
      fill_mem(8'd50, 8'd50);
      mem[0] = 8'd3; mem[5] = 8'hFE; mem[255] = 8'd7;
      run_vec("sparse", sparse_vec, 16'd8, 3, r0);
      chk("sparse_addr0", log_at(r0), 0);
      chk("sparse_addr1", log_at(r0 + 1), 5);
      chk("sparse_addr2", log_at(r0 + 2), 255);

      run_vec("empty", '0, 16'd0, 0, r0);

      fill_mem(8'd127, 8'd127);
      run_vec("all_127", '1, 16'd32512, 256, r0);
      // 8-bit weights over 256 axons top out at 32512, so the reachable
      // 16-bit boundary is the negative extreme and a sum that crosses zero.
      fill_mem(8'h80, 8'h80);
      run_vec("all_m128", '1, 16'h8000, 256, r0);
      fill_mem(8'd127, 8'h80);
      run_vec("alt_127_m128", '1, 16'hFF80, 256, r0);

      // Backpressure, with spike_vld pulses during SCAN and DONE
      fill_mem(8'd50, 8'd50);
      mem[0] = 8'd3; mem[5] = 8'hFE; mem[255] = 8'd7;
      wait_idle("bp");
      r0 = rd_log.size();
      bus.sum_rdy   = 1'b0;
      bus.spike_vec = sparse_vec;
      bus.spike_vld = 1'b1;
      @(negedge clk);
      bus.spike_vld = 1'b0;
      repeat (10) @(negedge clk);
      bus.spike_vec = '1;
      bus.spike_vld = 1'b1;
      good = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.spike_rdy === 1'b0) good++;
         @(negedge clk);
      end
      chk("bp_scan_rdy_low_cycles", good, 5);
      bus.spike_vld = 1'b0;
      n = 0;
      while (!bus.sum_vld && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("bp_sum_vld", bus.sum_vld, 1);
      bus.spike_vld = 1'b1;
      good = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.sum_vld === 1'b1 && bus.input_sum === 16'd8 && bus.spike_rdy === 1'b0) good++;
      end
      chk("bp_hold_stable_cycles", good, 10);
      chk("bp_sum", bus.input_sum, 16'd8);
      bus.spike_vld = 1'b0;
      bus.sum_rdy   = 1'b1;
      @(negedge clk);
      chk("bp_release_vld", bus.sum_vld, 0);
      chk("bp_release_rdy", bus.spike_rdy, 1);
      chk("bp_reads", rd_log.size() - r0, 3);
      $display("xfer bp: sum held for 10 cycles, reads=%0d", rd_log.size() - r0);

      // Asynchronous reset mid-scan, then a clean vector
      fill_mem(8'd127, 8'd127);
      wait_idle("mid_rst");
      bus.spike_vec = '1;
      bus.spike_vld = 1'b1;
      @(negedge clk);
      bus.spike_vld = 1'b0;
      n = 0;
      while (bus.wt_addr != IW'(100) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("mid_rst_at_idx", bus.wt_addr, 100);
      #2 rstb = 1'b0;
      #1;
      chk("mid_rst_spike_rdy", bus.spike_rdy, 1);
      chk("mid_rst_sum_vld", bus.sum_vld, 0);
      chk("mid_rst_wt_rd_en", bus.wt_rd_en, 0);
      chk("mid_rst_input_sum", bus.input_sum, 0);
      @(negedge clk);
      rstb = 1'b1;
      mem[1] = 8'd9;
      run_vec("post_rst", 256'h2, 16'd9, 1, r0);
      chk("post_rst_addr", log_at(r0), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
